seg_scan_driver: RTL and testbench

//  Time-multiplexes the eight 7-segment codes produced by the display/blink stage onto one shared

---
 rtl/seg_scan_driver_pkg.sv | 20 ++
 rtl/seg_scan_driver_if.sv | 28 ++
 rtl/seg_scan_driver_scan_tick_gen.sv | 36 +++
 rtl/seg_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg_scan_driver.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the 8-digit multiplexed 7-segment scan driver.
package seg_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_DARK   = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_DEAD = 1'b1
    } scan_state_e;

    typedef logic [2:0] digit_idx_t;

    // Active-low one-hot digit enable for the selected digit.
    function automatic logic [7:0] an_decode(input digit_idx_t idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: digit codes and enable in, multiplexed pin drive out.
interface seg_scan_if;
    import seg_pkg::*;

    logic                  enable;
    logic [6:0]            led0;
    logic [6:0]            led1;
    logic [6:0]            led2;
    logic [6:0]            led3;
    logic [6:0]            led4;
    logic [6:0]            led5;
    logic [6:0]            led6;
    logic [6:0]            led7;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_start;

    // master: the display/blink stage feeding codes; slave: the scan driver.
    modport master (
        output enable, led0, led1, led2, led3, led4, led5, led6, led7,
        input  seg, an, frame_start
    );

    modport slave (
        input  enable, led0, led1, led2, led3, led4, led5, led6, led7,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg_scan_driver_scan_tick_gen.sv
// Per-digit slot prescaler: counts 0..DIV-1 with a synchronous clear; tick at terminal count.
module scan_tick_gen
    import seg_pkg::*;
#(
    parameter int DIV = 10,
    parameter int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));
    assign cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit 7-segment scan driver with frame-synchronous shadow capture.
// Optional blanking at the start of every slot when SEG_SCAN_DEADTIME_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    seg_scan_if.slave bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [NUM_DIGITS-1:0][6:0] led_in;
    logic [NUM_DIGITS-1:0][6:0] shadow_q;
    logic [NUM_DIGITS-1:0][6:0] shadow_d;
    digit_idx_t                 idx_q;
    digit_idx_t                 idx_d;
    logic [6:0]                 seg_q;
    logic [6:0]                 seg_d;
    logic [NUM_DIGITS-1:0]      an_q;
    logic [NUM_DIGITS-1:0]      an_d;
    logic                       frame_start_q;
    logic                       frame_start_d;
    scan_state_e                state_q;
    scan_state_e                state_d;
    logic                       run_q;

    logic          en;
    logic          start;
    logic          slot_begin;
    logic          frame_load;
    logic          tick;
    logic [CW-1:0] cnt;
    logic [6:0]    drive_seg;
    logic [7:0]    drive_an;

    assign led_in = {bus.led7, bus.led6, bus.led5, bus.led4,
                     bus.led3, bus.led2, bus.led1, bus.led0};

    // First enabled cycle after idle/reset restarts the frame as if a boundary had occurred.
    assign en         = bus.enable;
    assign start      = en && !run_q;
    assign slot_begin = start || (en && run_q && tick);
    assign frame_load = start || (en && run_q && tick && (idx_q == 3'd7));

    scan_tick_gen #(
        .DIV (DIV),
        .CW  (CW)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en || start),
        .tick  (tick),
        .cnt   (cnt)
    );

    always_comb begin
        idx_d = idx_q;
        if (!en || start) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = idx_q + 3'd1;
        end
    end

    // Shadow and new index feed the output registers directly so seg/an change on the load edge.
    assign shadow_d      = frame_load ? led_in : shadow_q;
    assign drive_seg     = shadow_d[idx_d];
    assign drive_an      = an_decode(idx_d);
    assign frame_start_d = frame_load;

    always_comb begin
        seg_d   = seg_q;
        an_d    = an_q;
        state_d = state_q;
        if (!en) begin
            seg_d   = SEG_DARK;
            an_d    = AN_OFF;
            state_d = ST_SCAN;
        end else if (slot_begin) begin
`ifdef SEG_SCAN_DEADTIME_EN
            if (DEAD_CYCLES > 0) begin
                seg_d   = SEG_DARK;
                an_d    = AN_OFF;
                state_d = ST_DEAD;
            end else begin
                seg_d   = drive_seg;
                an_d    = drive_an;
                state_d = ST_SCAN;
            end
        end else if ((state_q == ST_DEAD) && (cnt == CW'(DEAD_CYCLES - 1))) begin
            seg_d   = drive_seg;
            an_d    = drive_an;
            state_d = ST_SCAN;
`else
            seg_d   = drive_seg;
            an_d    = drive_an;
`endif
        end
    end

`ifndef SEG_SCAN_DEADTIME_EN
    logic unused_dead;
    assign unused_dead = ^{cnt, (DEAD_CYCLES < DIV)};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= {NUM_DIGITS{SEG_DARK}};
            idx_q         <= '0;
            seg_q         <= SEG_DARK;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
            state_q       <= ST_SCAN;
            run_q         <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
            state_q       <= state_d;
            run_q         <= en;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (DIV=10, DEAD_CYCLES=3); follows SEG_SCAN_DEADTIME_EN if defined.
module tb_seg_scan_driver;

    localparam int DIV   = 10;
    localparam int FRAME = 80;
`ifdef SEG_SCAN_DEADTIME_EN
    localparam int DEAD_EXP = 3;
`else
    localparam int DEAD_EXP = 0;
`endif

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0][6:0] codes;

    seg_scan_if bus();

    seg_scan_driver #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .DEAD_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic set_leds(input logic [7:0][6:0] c);
        bus.led0 = c[0]; bus.led1 = c[1]; bus.led2 = c[2]; bus.led3 = c[3];
        bus.led4 = c[4]; bus.led5 = c[5]; bus.led6 = c[6]; bus.led7 = c[7];
    endtask

    // Expected pins for the first n cycles of a frame started with codes c.
    function automatic void push_frame(input logic [7:0][6:0] c, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            int   slot;
            int   pos;
            slot = k / DIV;
            pos  = k % DIV;
            e.fs = (k == 0);
            if (pos < DEAD_EXP) begin
                e.an  = 8'hFF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(8'h01 << slot);
                e.seg = c[slot];
            end
            sb.push_back(e);
        end
    endfunction

    function automatic void push_dark(input int n);
        exp_t e;
        e.an  = 8'hFF;
        e.seg = 7'h7F;
        e.fs  = 1'b0;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endfunction

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.enable = 1'b1;
        codes = {7'h10, 7'h02, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        set_leds(codes);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.an !== 8'hFF || bus.seg !== 7'h7F || bus.frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL reset k=%0d got an=%h seg=%h fs=%b want an=ff seg=7f fs=0",
                         k, bus.an, bus.seg, bus.frame_start);
            end
        end
        $display("reset: 3 cycles checked");
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        push_frame(codes, FRAME);
        push_frame(codes, FRAME);
        for (int k = 0; k < 2 * FRAME; k++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL scan k=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                         k, bus.an, bus.seg, bus.frame_start, e.an, e.seg, e.fs);
            end
            if (bus.frame_start === 1'b1) $display("scan: frame_start at k=%0d", k);
        end
    endtask

    task automatic test_anti_tear();
        logic [7:0][6:0] newc;
        newc    = codes;
        newc[3] = 7'h12;
        push_frame(codes, FRAME);
        push_frame(newc, FRAME);
        for (int k = 0; k < 2 * FRAME; k++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL anti_tear k=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                         k, bus.an, bus.seg, bus.frame_start, e.an, e.seg, e.fs);
            end
            if (k == 50) begin
                codes = newc;
                set_leds(codes);
            end
            if (bus.frame_start === 1'b1) $display("anti_tear: frame_start at k=%0d", k);
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0][6:0] c2;
        c2 = {7'h00, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7E, 7'h3F};
        push_frame(codes, 60);
        push_dark(3);
        push_frame(c2, FRAME);
        for (int k = 0; k < 63 + FRAME; k++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL enable_drop k=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                         k, bus.an, bus.seg, bus.frame_start, e.an, e.seg, e.fs);
            end
            // Drop lands on the same edge as a slot tick at idx 5.
            if (k == 59) bus.enable = 1'b0;
            if (k == 62) begin
                codes = c2;
                set_leds(codes);
                bus.enable = 1'b1;
            end
            if (bus.frame_start === 1'b1) $display("enable_drop: frame_start at k=%0d", k);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0][6:0] c3;
        c3 = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66, 7'h77, 7'h01};
        push_frame(codes, 66);
        push_dark(1);
        push_frame(c3, FRAME);
        for (int k = 0; k < 67 + FRAME; k++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (bus.an !== e.an || bus.seg !== e.seg || bus.frame_start !== e.fs) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d got an=%h seg=%h fs=%b want an=%h seg=%h fs=%b",
                         k, bus.an, bus.seg, bus.frame_start, e.an, e.seg, e.fs);
            end
            if (k == 65) rst_n = 1'b0;
            if (k == 66) begin
                rst_n = 1'b1;
                codes = c3;
                set_leds(codes);
            end
            if (bus.frame_start === 1'b1) $display("reset_mid: frame_start at k=%0d", k);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_anti_tear();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
